// File: rtl/mem_tp_pkg.sv
// Shared constants and helpers for the two-port memory read controller.
package mem_tp_pkg;

  localparam int RD_LATENCY_MAX = 3;

  // Width able to hold 0..depth inclusive (credit and occupancy counters).
  function automatic int credit_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/mem_tp_rd_fifo.sv
// First-word-fall-through response FIFO: the head entry is visible on o_head_data whenever
// o_count is non-zero. The producer guarantees it never pushes into a full FIFO.
module mem_tp_rd_fifo
  import mem_tp_pkg::*;
#(
  parameter int DW    = 128,
  parameter int DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           i_push,
  input  logic [DW-1:0]                  i_push_data,
  input  logic                           i_pop,
  output logic [DW-1:0]                  o_head_data,
  output logic [credit_width(DEPTH)-1:0] o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = credit_width(DEPTH);

  logic [DW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  // Storage carries no reset; occupancy is tracked solely by the pointers and count.
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (i_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head_data = r_mem[r_rd_ptr];
  assign o_count     = r_count;

endmodule

// File: rtl/mem_tp_rd_ctrl.sv
// Read-side controller for a 1W/1R memory: credit-gated request issue, latency pipeline and FWFT
// response buffer. Define MEM_TP_RD_FWD_EN for write-first forwarding of same-cycle port-A writes.
module mem_tp_rd_ctrl
  import mem_tp_pkg::*;
#(
  parameter int MEM_DATAWIDTH  = 128,
  parameter int MEM_ADDRWIDTH  = 14,
  parameter int RD_LATENCY     = 1,
  parameter int RSP_FIFO_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [MEM_ADDRWIDTH-1:0] req_addr,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [MEM_DATAWIDTH-1:0] rsp_data,
  output logic                     mem_enb,
  output logic [MEM_ADDRWIDTH-1:0] mem_addrb,
  input  logic [MEM_DATAWIDTH-1:0] mem_doutb,
  input  logic                     snp_ena,
  input  logic [MEM_DATAWIDTH-1:0] snp_wea,
  input  logic [MEM_ADDRWIDTH-1:0] snp_addra,
  input  logic [MEM_DATAWIDTH-1:0] snp_dina
);

  // Latencies beyond the supported maximum are clamped to it.
  localparam int LAT = (RD_LATENCY > RD_LATENCY_MAX) ? RD_LATENCY_MAX : RD_LATENCY;
  localparam int CW  = credit_width(RSP_FIFO_DEPTH);

  logic [CW-1:0]            r_credit;
  logic [LAT-1:0]           r_vld;
  logic                     w_accept;
  logic                     w_pop;
  logic                     w_push;
  logic [MEM_DATAWIDTH-1:0] w_push_data;
  logic [CW-1:0]            w_fifo_count;

  assign req_ready = (r_credit != '0);
  assign w_accept  = req_valid & req_ready;
  assign mem_enb   = w_accept;
  assign mem_addrb = req_addr;
  assign w_pop     = rsp_valid & rsp_ready;
  assign rsp_valid = (w_fifo_count != '0);

  // One credit per buffer slot, held from accept until the response leaves the FIFO,
  // so a stalled client can never cause an overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_credit <= CW'(RSP_FIFO_DEPTH);
    end else begin
      case ({w_accept, w_pop})
        2'b10:   r_credit <= r_credit - CW'(1);
        2'b01:   r_credit <= r_credit + CW'(1);
        default: r_credit <= r_credit;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld <= '0;
    end else begin
      r_vld <= (r_vld << 1) | LAT'(w_accept);
    end
  end

  assign w_push = r_vld[LAT-1];

`ifdef MEM_TP_RD_FWD_EN
  logic [MEM_DATAWIDTH-1:0] r_fwd_mask [LAT];
  logic [MEM_DATAWIDTH-1:0] r_fwd_data [LAT];
  logic [MEM_DATAWIDTH-1:0] w_hit_mask;

  // Only a write coinciding with the accept cycle is merged; later writes are visible
  // through the memory itself on subsequent reads.
  assign w_hit_mask = (snp_ena && (snp_addra == req_addr)) ? snp_wea : '0;

  always_ff @(posedge clk) begin
    r_fwd_mask[0] <= w_hit_mask;
    r_fwd_data[0] <= snp_dina;
    for (int i = LAT - 1; i > 0; i--) begin
      r_fwd_mask[i] <= r_fwd_mask[i-1];
      r_fwd_data[i] <= r_fwd_data[i-1];
    end
  end

  assign w_push_data = (mem_doutb & ~r_fwd_mask[LAT-1]) | (r_fwd_data[LAT-1] & r_fwd_mask[LAT-1]);
`else
  logic w_unused_snoop;

  assign w_unused_snoop = ^{snp_ena, snp_wea, snp_addra, snp_dina};
  assign w_push_data    = mem_doutb;
`endif

  mem_tp_rd_fifo #(
    .DW    (MEM_DATAWIDTH),
    .DEPTH (RSP_FIFO_DEPTH)
  ) u_rsp_fifo (
    .clk         (clk),
    .reset       (reset),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .o_head_data (rsp_data),
    .o_count     (w_fifo_count)
  );

endmodule
